// File: rtl/float_pkg.sv
// Shared float helpers: exponent bias, conversion class enum and signed integer limits.
// Integer limits are built at a wide width and sliced down by the caller.
package float_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_OVERFLOW,
    CLS_NAN
  } cls_t;

  localparam int MAX_INT_W = 128;

  function automatic int float_bias(input int exponent_size);
    return (1 << (exponent_size - 1)) - 1;
  endfunction

  function automatic logic [MAX_INT_W-1:0] int_min(input int width);
    return {{(MAX_INT_W-1){1'b0}}, 1'b1} << (width - 1);
  endfunction

  function automatic logic [MAX_INT_W-1:0] int_max(input int width);
    return int_min(width) - MAX_INT_W'(1);
  endfunction

endpackage

// File: rtl/float_classify.sv
// Combinational float unpack/classify: class, sign, mantissa with hidden bit, shift direction/amount.
// Purely combinational; shift amount is only meaningful for CLS_NORMAL.
module float_classify
  import float_pkg::*;
#(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  parameter int INT_SIZE      = 32
) (
  input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] f,
  output cls_t                                 cls,
  output logic                                 sign,
  output logic [MANTISSA_SIZE:0]               m,
  output logic                                 shift_left,
  output logic [$clog2(INT_SIZE)-1:0]          shift_amt
);

  localparam int SHW  = $clog2(INT_SIZE);
  localparam int BIAS = float_bias(EXPONENT_SIZE);

  logic [EXPONENT_SIZE-1:0] exponent;
  logic [MANTISSA_SIZE-1:0] mantissa;
  int                       e;

  assign sign     = f[EXPONENT_SIZE+MANTISSA_SIZE];
  assign exponent = f[EXPONENT_SIZE+MANTISSA_SIZE-1 -: EXPONENT_SIZE];
  assign mantissa = f[MANTISSA_SIZE-1:0];
  assign m        = {|exponent, mantissa};

  always_comb begin
    e          = int'(exponent) - BIAS;
    shift_left = (e >= MANTISSA_SIZE);
    shift_amt  = shift_left ? SHW'(e - MANTISSA_SIZE) : SHW'(MANTISSA_SIZE - e);
    if (&exponent)
      cls = (|mantissa) ? CLS_NAN : CLS_OVERFLOW;
    else if (e < 0)
      cls = CLS_ZERO;
    else if (e >= INT_SIZE - 1)
      // -2^(INT_SIZE-1) is the one value at this exponent that still fits
      cls = (sign && (e == INT_SIZE - 1) && (mantissa == '0)) ? CLS_NORMAL : CLS_OVERFLOW;
    else
      cls = CLS_NORMAL;
  end

endmodule

// File: rtl/float_to_int.sv
// Float to signed integer, truncating toward zero; 4-cycle latency, 1/clk, no backpressure.
// Build option FLOAT_TO_INT_SATURATE_EN: saturate overflow/Inf and zero NaN instead of INT_MIN.
module float_to_int
  import float_pkg::*;
#(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  parameter int INT_SIZE      = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] in,
  output logic                                 out_valid,
  output logic [INT_SIZE-1:0]                  out,
  output logic                                 out_overflow
);

  localparam int SHW = $clog2(INT_SIZE);
  localparam logic [INT_SIZE-1:0] MIN_V = INT_SIZE'(int_min(INT_SIZE));
`ifdef FLOAT_TO_INT_SATURATE_EN
  localparam logic [INT_SIZE-1:0] MAX_V = INT_SIZE'(int_max(INT_SIZE));
`endif

  logic [3:0] vld;

  cls_t                 c_cls;
  logic                 c_sign;
  logic [MANTISSA_SIZE:0] c_m;
  logic                 c_left;
  logic [SHW-1:0]       c_amt;

  cls_t                 s1_cls, s2_cls, s3_cls;
  logic                 s1_sign, s2_sign;
  logic [MANTISSA_SIZE:0] s1_m;
  logic                 s1_left;
  logic [SHW-1:0]       s1_amt;
  logic [INT_SIZE-1:0]  s1_ext, s2_mag, s3_val, s4_res;
  logic                 s4_ovf;
`ifdef FLOAT_TO_INT_SATURATE_EN
  logic                 s3_sign;
`endif

  float_classify #(
    .MANTISSA_SIZE(MANTISSA_SIZE),
    .EXPONENT_SIZE(EXPONENT_SIZE),
    .INT_SIZE     (INT_SIZE)
  ) u_classify (
    .f         (in),
    .cls       (c_cls),
    .sign      (c_sign),
    .m         (c_m),
    .shift_left(c_left),
    .shift_amt (c_amt)
  );

  assign s1_ext = {{(INT_SIZE-MANTISSA_SIZE-1){1'b0}}, s1_m};

  // Data stages load every cycle; only the valid pipe is qualifying.
  always_ff @(posedge clk) begin
    s1_cls  <= c_cls;
    s1_sign <= c_sign;
    s1_m    <= c_m;
    s1_left <= c_left;
    s1_amt  <= c_amt;

    s2_cls  <= s1_cls;
    s2_sign <= s1_sign;
    s2_mag  <= s1_left ? (s1_ext << s1_amt) : (s1_ext >> s1_amt);

    s3_cls  <= s2_cls;
    s3_val  <= s2_sign ? -s2_mag : s2_mag;
`ifdef FLOAT_TO_INT_SATURATE_EN
    s3_sign <= s2_sign;
`endif
  end

  always_comb begin
    s4_res = s3_val;
    s4_ovf = 1'b0;
    case (s3_cls)
      CLS_ZERO:   s4_res = '0;
      CLS_NORMAL: s4_res = s3_val;
      CLS_OVERFLOW: begin
        s4_ovf = 1'b1;
`ifdef FLOAT_TO_INT_SATURATE_EN
        s4_res = s3_sign ? MIN_V : MAX_V;
`else
        s4_res = MIN_V;
`endif
      end
      CLS_NAN: begin
        s4_ovf = 1'b1;
`ifdef FLOAT_TO_INT_SATURATE_EN
        s4_res = '0;
`else
        s4_res = MIN_V;
`endif
      end
      default: s4_res = s3_val;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld          <= '0;
      out          <= '0;
      out_overflow <= 1'b0;
    end else begin
      vld          <= {vld[2:0], in_valid};
      out          <= s4_res;
      out_overflow <= s4_ovf;
    end
  end

  assign out_valid = vld[3];

endmodule

// File: tb/tb_float_to_int.sv
// Scoreboard bench for float_to_int: directed vectors, random stream, reset mid-burst.
module tb_float_to_int;

  typedef struct {
    logic [31:0] f;
    logic [31:0] val;
    logic        ov;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in;
  logic        out_valid;
  logic [31:0] out;
  logic        out_overflow;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  float_to_int dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in          (in),
    .out_valid   (out_valid),
    .out         (out),
    .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Directed vectors: input, plain-build result, saturate-build result, overflow.
  logic [31:0] d_in   [16];
  logic [31:0] d_plain[16];
  logic [31:0] d_sat  [16];
  logic        d_ov   [16];

  initial begin
    d_in    = '{32'h3F800000, 32'hC0700000, 32'h3F7FFFFF, 32'h00000001,
                32'h80000000, 32'h4EFFFFFF, 32'hCF000000, 32'h4F000000,
                32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h40490FDB,
                32'hC2F6E979, 32'hCF000001, 32'h4B000001, 32'hFFC00000};
    d_plain = '{32'h00000001, 32'hFFFFFFFD, 32'h00000000, 32'h00000000,
                32'h00000000, 32'h7FFFFF80, 32'h80000000, 32'h80000000,
                32'h80000000, 32'h80000000, 32'h80000000, 32'h00000003,
                32'hFFFFFF85, 32'h80000000, 32'h00800001, 32'h80000000};
    d_sat   = '{32'h00000001, 32'hFFFFFFFD, 32'h00000000, 32'h00000000,
                32'h00000000, 32'h7FFFFF80, 32'h80000000, 32'h7FFFFFFF,
                32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h00000003,
                32'hFFFFFF85, 32'h80000000, 32'h00800001, 32'h00000000};
    d_ov    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  end

  function automatic logic [31:0] special_val(input logic sign, input logic nan);
`ifdef FLOAT_TO_INT_SATURATE_EN
    if (nan) return 32'h00000000;
    return sign ? 32'h80000000 : 32'h7FFFFFFF;
`else
    return 32'h80000000;
`endif
  endfunction

  // C-style truncating conversion with an explicit range check on a 64-bit value.
  function automatic void model(input logic [31:0] f, output logic [31:0] v, output logic ov);
    int     ex;
    int     e;
    longint mant;
    longint mag;
    longint sv;
    ex   = int'(f[30:23]);
    mant = longint'({1'b1, f[22:0]});
    v    = 32'h0;
    ov   = 1'b0;
    if (ex == 255) begin
      ov = 1'b1;
      v  = special_val(f[31], f[22:0] != 23'h0);
    end else if (ex >= 127) begin
      e = ex - 127;
      if (e > 40) begin
        ov = 1'b1;
        v  = special_val(f[31], 1'b0);
      end else begin
        mag = (e >= 23) ? (mant << (e - 23)) : (mant >> (23 - e));
        sv  = f[31] ? -mag : mag;
        if (sv > 64'sd2147483647 || sv < -64'sd2147483648) begin
          ov = 1'b1;
          v  = special_val(f[31], 1'b0);
        end else begin
          v = sv[31:0];
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] f, input logic [31:0] val, input logic ov);
    exp_t x;
    in_valid = 1'b1;
    in       = f;
    x.f      = f;
    x.val    = val;
    x.ov     = ov;
    x.cyc    = cyc;
    sbq.push_back(x);
    step();
  endtask

  task automatic issue_dir(input int i);
`ifdef FLOAT_TO_INT_SATURATE_EN
    issue(d_in[i], d_sat[i], d_ov[i]);
`else
    issue(d_in[i], d_plain[i], d_ov[i]);
`endif
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      in       = $urandom;
      step();
    end
  endtask

  // Monitor: pops one expectation per valid output and checks value, flag and latency.
  always @(negedge clk) begin
    exp_t x;
    if (out_valid) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: out=%h ovf=%b with nothing outstanding", out, out_overflow);
      end else begin
        x = sbq.pop_front();
        if (out !== x.val || out_overflow !== x.ov || (cyc - x.cyc) != 4) begin
          errors++;
          $display("FAIL result in=%h: got out=%h ovf=%b latency=%0d, expected out=%h ovf=%b latency=4",
                   x.f, out, out_overflow, cyc - x.cyc, x.val, x.ov);
        end
      end
    end else if (sbq.size() != 0 && sbq[0].cyc + 4 <= cyc) begin
      checks++;
      errors++;
      x = sbq.pop_front();
      $display("FAIL missing_output in=%h: out_valid=0 at latency %0d, expected 1", x.f, cyc - x.cyc);
    end
    if (reset) sbq.delete();
  end

  initial begin
    logic [31:0] f;
    logic [31:0] v;
    logic        ov;
    int          wait_cyc;

    reset    = 1'b1;
    in_valid = 1'b1;
    in       = 32'h3F800000;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    checks++;
    if (out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h, expected 00000000", out); end
    checks++;
    if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, expected 0", out_overflow); end
    reset    = 1'b0;
    in_valid = 1'b0;
    idle(3);

    // Lone 1.0, then the whole directed table back-to-back.
    issue_dir(0);
    idle(6);
    for (int i = 0; i < 16; i++) issue_dir(i);
    idle(6);

    // Random stream with in_valid toggled; half the floats are kept near the integer range.
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        f = $urandom;
        if ($urandom_range(0, 1) == 1) f[30:23] = 8'($urandom_range(110, 165));
        model(f, v, ov);
        issue(f, v, ov);
      end
    end
    idle(6);

    // Reset for one cycle in the middle of a burst; in_valid during reset is ignored.
    issue_dir(1);
    issue_dir(5);
    issue_dir(12);
    reset    = 1'b1;
    in_valid = 1'b1;
    in       = 32'h3F800000;
    step();
    reset = 1'b0;
    issue_dir(0);
    issue_dir(6);
    issue_dir(8);
    idle(1);

    wait_cyc = 0;
    while (sbq.size() != 0 && wait_cyc < 20) begin
      idle(1);
      wait_cyc++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results still outstanding, expected 0", sbq.size());
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
